// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

    typedef enum int {PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2} uart_parity_t;

    // Clocks per oversample tick, floored.
    function automatic int unsigned calc_baud_div(input longint unsigned clock_rate,
                                                  input longint unsigned baud_rate,
                                                  input longint unsigned oversample);
        return unsigned'(32'(clock_rate / (baud_rate * oversample)));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator; clr_i realigns the count to a start edge.
module uart_baud_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_led_param.sv
// Oversampling UART receiver with configurable framing, driving an LED bank and
// exporting each received character with its error flags.
module uart_led_param
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 200_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned LED_WIDTH  = 8,
    parameter int unsigned LED_MODE   = 0
) (
    input  logic                 clk_rx,
    input  logic                 rst_n_clk_rx,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_data_rdy_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic [LED_WIDTH-1:0] led_o
);

    localparam int unsigned DIV = calc_baud_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam bit PAR_EN  = (PARITY != unsigned'(PAR_NONE));
    localparam bit PAR_INV = (PARITY == unsigned'(PAR_ODD));

    if (DIV < 1) begin : g_chk_div
        $error("uart_led_param: CLOCK_RATE too low for BAUD_RATE * OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_chk_os
        $error("uart_led_param: OVERSAMPLE must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_bits
        $error("uart_led_param: DATA_BITS must be 5..9");
    end
    if ((LED_WIDTH < DATA_BITS) || (PARITY > 2) || (LED_MODE > 1)) begin : g_chk_cfg
        $error("uart_led_param: illegal LED_WIDTH, PARITY or LED_MODE");
    end

    logic                 rxd_meta_q, rxd_sync_q;
    uart_rx_state_t       state_q;
    logic [SW-1:0]        smp_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_acc_q, par_bad_q;
    logic                 tick, baud_clr;
    logic [LED_WIDTH-1:0] led_next;

    // Idle-high synchroniser so reset never looks like a start edge.
    always_ff @(posedge clk_rx or negedge rst_n_clk_rx) begin
        if (!rst_n_clk_rx) begin
            {rxd_sync_q, rxd_meta_q} <= 2'b11;
        end else begin
            {rxd_sync_q, rxd_meta_q} <= {rxd_meta_q, rxd_i};
        end
    end

    assign baud_clr = (state_q == IDLE) && !rxd_sync_q;

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud_gen (
        .clk_i (clk_rx),
        .rst_ni(rst_n_clk_rx),
        .clr_i (baud_clr),
        .tick_o(tick)
    );

    if ((LED_MODE == 0) || (LED_WIDTH == DATA_BITS)) begin : g_led_direct
        assign led_next = LED_WIDTH'(shift_q);
    end else begin : g_led_shift
        assign led_next = {led_o[LED_WIDTH-DATA_BITS-1:0], shift_q};
    end

    always_ff @(posedge clk_rx or negedge rst_n_clk_rx) begin
        if (!rst_n_clk_rx) begin
            state_q       <= IDLE;
            smp_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            par_acc_q     <= 1'b0;
            par_bad_q     <= 1'b0;
            rx_data_o     <= '0;
            rx_data_rdy_o <= 1'b0;
            frame_err_o   <= 1'b0;
            parity_err_o  <= 1'b0;
            led_o         <= '0;
        end else begin
            rx_data_rdy_o <= 1'b0;
            frame_err_o   <= 1'b0;
            parity_err_o  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!rxd_sync_q) begin
                        state_q <= START;
                        smp_q   <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (smp_q == SMP_MID) begin
                            smp_q     <= '0;
                            bit_q     <= '0;
                            par_acc_q <= 1'b0;
                            par_bad_q <= 1'b0;
                            state_q   <= rxd_sync_q ? IDLE : DATA;
                        end else begin
                            smp_q <= smp_q + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (smp_q == SMP_LAST) begin
                            smp_q     <= '0;
                            shift_q   <= {rxd_sync_q, shift_q[DATA_BITS-1:1]};
                            par_acc_q <= par_acc_q ^ rxd_sync_q;
                            if (bit_q == BIT_LAST) begin
                                state_q <= PAR_EN ? uart_pkg::PARITY : STOP;
                            end else begin
                                bit_q <= bit_q + BW'(1);
                            end
                        end else begin
                            smp_q <= smp_q + SW'(1);
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) begin
                        if (smp_q == SMP_LAST) begin
                            smp_q     <= '0;
                            par_bad_q <= (rxd_sync_q != (par_acc_q ^ PAR_INV));
                            state_q   <= STOP;
                        end else begin
                            smp_q <= smp_q + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (smp_q == SMP_LAST) begin
                            smp_q        <= '0;
                            rx_data_o    <= shift_q;
                            frame_err_o  <= !rxd_sync_q;
                            parity_err_o <= par_bad_q;
                            if (rxd_sync_q && !par_bad_q) begin
                                rx_data_rdy_o <= 1'b1;
                                led_o         <= led_next;
                            end
                            state_q <= IDLE;
                        end else begin
                            smp_q <= smp_q + SW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_led_param.sv
// Randomised bench for uart_led_param: four framing/LED configurations checked every
// cycle against a character-level model of what each serial frame must produce.
module tb_uart_led_param;

    localparam int ND      = 4;
    localparam int CLK_BIT = 160;

    typedef struct {
        int due;
        int data;
        bit ok;
        bit fe;
        bit pe;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [ND-1:0] rxd   = '1;
    int            cyc   = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    bit            checking = 1'b0;

    int nb_cfg   [ND] = '{8, 8, 8, 7};
    int par_cfg  [ND] = '{0, 2, 0, 1};
    int mode_cfg [ND] = '{0, 0, 1, 1};
    int lw_cfg   [ND] = '{8, 8, 16, 8};

    exp_t q [ND][$];
    int   m_data [ND];
    int   m_led  [ND];

    logic [7:0]    dat_a, dat_b, dat_c, led_a, led_b, led_d;
    logic [6:0]    dat_d;
    logic [15:0]   led_c;
    logic [ND-1:0] rdy, fe, pe;
    int            o_data [ND];
    int            o_led  [ND];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        o_data[0] = int'(dat_a);
        o_data[1] = int'(dat_b);
        o_data[2] = int'(dat_c);
        o_data[3] = int'(dat_d);
        o_led[0]  = int'(led_a);
        o_led[1]  = int'(led_b);
        o_led[2]  = int'(led_c);
        o_led[3]  = int'(led_d);
    end

    uart_led_param #(
        .CLOCK_RATE(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .LED_WIDTH(8), .LED_MODE(0)
    ) u_a (
        .clk_rx(clk), .rst_n_clk_rx(rst_n), .rxd_i(rxd[0]), .rx_data_o(dat_a),
        .rx_data_rdy_o(rdy[0]), .frame_err_o(fe[0]), .parity_err_o(pe[0]), .led_o(led_a)
    );

    uart_led_param #(
        .CLOCK_RATE(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(2), .LED_WIDTH(8), .LED_MODE(0)
    ) u_b (
        .clk_rx(clk), .rst_n_clk_rx(rst_n), .rxd_i(rxd[1]), .rx_data_o(dat_b),
        .rx_data_rdy_o(rdy[1]), .frame_err_o(fe[1]), .parity_err_o(pe[1]), .led_o(led_b)
    );

    uart_led_param #(
        .CLOCK_RATE(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .LED_WIDTH(16), .LED_MODE(1)
    ) u_c (
        .clk_rx(clk), .rst_n_clk_rx(rst_n), .rxd_i(rxd[2]), .rx_data_o(dat_c),
        .rx_data_rdy_o(rdy[2]), .frame_err_o(fe[2]), .parity_err_o(pe[2]), .led_o(led_c)
    );

    uart_led_param #(
        .CLOCK_RATE(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
        .DATA_BITS(7), .PARITY(1), .LED_WIDTH(8), .LED_MODE(1)
    ) u_d (
        .clk_rx(clk), .rst_n_clk_rx(rst_n), .rxd_i(rxd[3]), .rx_data_o(dat_d),
        .rx_data_rdy_o(rdy[3]), .frame_err_o(fe[3]), .parity_err_o(pe[3]), .led_o(led_d)
    );

    task automatic chk(input string nm, input int d, input bit pass, input int act,
                       input int want);
        n_chk++;
        if (!pass) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h, want 0x%0h", nm, d, cyc, act, want);
        end
    endtask

    function automatic int led_model(input int d, input int old, input int ch);
        longint mask;
        mask = (longint'(1) << lw_cfg[d]) - 1;
        if (mode_cfg[d] == 0) return ch;
        return int'(((longint'(old) << nb_cfg[d]) | longint'(ch)) & mask);
    endfunction

    task automatic compare_dut(input int d);
        exp_t e;
        if (rdy[d] || fe[d] || pe[d]) begin
            chk("pulse_expected", d, q[d].size() != 0, q[d].size(), 1);
            if (q[d].size() != 0) begin
                e = q[d].pop_front();
                chk("pulse_time", d, (cyc >= e.due - 8) && (cyc <= e.due + 16), cyc, e.due);
                chk("rx_data_rdy", d, rdy[d] == e.ok, int'(rdy[d]), int'(e.ok));
                chk("frame_err", d, fe[d] == e.fe, int'(fe[d]), int'(e.fe));
                chk("parity_err", d, pe[d] == e.pe, int'(pe[d]), int'(e.pe));
                m_data[d] = e.data;
                if (e.ok) m_led[d] = led_model(d, m_led[d], e.data);
            end
        end else if ((q[d].size() != 0) && (cyc > q[d][0].due + 16)) begin
            chk("pulse_missing", d, 1'b0, 0, 1);
            void'(q[d].pop_front());
        end
        chk("rx_data", d, o_data[d] == m_data[d], o_data[d], m_data[d]);
        chk("led", d, o_led[d] == m_led[d], o_led[d], m_led[d]);
    endtask

    always @(negedge clk) begin
        if (rst_n && checking) begin
            for (int d = 0; d < ND; d++) compare_dut(d);
        end
    end

    task automatic drive(input int d, input bit b, input int n);
        rxd[d] = b;
        repeat (n) @(negedge clk);
    endtask

    // One frame; a forced-low stop bit is released early so it cannot pose as a start bit.
    task automatic send_frame(input int d, input int ch, input bit bad_par, input bit bad_stop);
        exp_t e;
        int   total;
        int   ones;
        bit   pbit;
        ones  = $countones(ch);
        pbit  = ones[0] ^ (par_cfg[d] == 1) ^ bad_par;
        total = 2 + nb_cfg[d] + ((par_cfg[d] != 0) ? 1 : 0);
        e.due  = cyc + (total - 1) * CLK_BIT + CLK_BIT / 2;
        e.data = ch;
        e.fe   = bad_stop;
        e.pe   = (par_cfg[d] != 0) && bad_par;
        e.ok   = !e.fe && !e.pe;
        q[d].push_back(e);
        drive(d, 1'b0, CLK_BIT);
        for (int i = 0; i < nb_cfg[d]; i++) drive(d, bit'((ch >> i) & 1), CLK_BIT);
        if (par_cfg[d] != 0) drive(d, pbit, CLK_BIT);
        if (bad_stop) begin
            drive(d, 1'b0, 120);
            drive(d, 1'b1, 40);
        end else begin
            drive(d, 1'b1, CLK_BIT);
        end
    endtask

    task automatic rand_seq(input int d, input int n);
        int  ch;
        bit  bp;
        bit  bs;
        int  gap;
        for (int i = 0; i < n; i++) begin
            ch  = int'($urandom_range(0, (1 << nb_cfg[d]) - 1));
            bp  = (par_cfg[d] != 0) && ($urandom_range(0, 3) == 0);
            bs  = ($urandom_range(0, 4) == 0);
            send_frame(d, ch, bp, bs);
            gap = bs ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            if (gap != 0) drive(d, 1'b1, gap * CLK_BIT);
        end
        drive(d, 1'b1, 2 * CLK_BIT);
    endtask

    task automatic check_all_zero(input string nm);
        for (int d = 0; d < ND; d++) begin
            chk({nm, "_data"}, d, o_data[d] == 0, o_data[d], 0);
            chk({nm, "_led"}, d, o_led[d] == 0, o_led[d], 0);
            chk({nm, "_pulses"}, d, {rdy[d], fe[d], pe[d]} == 3'b000,
                int'({rdy[d], fe[d], pe[d]}), 0);
        end
    endtask

    task automatic lit(input string nm, input int d, input int act, input int want);
        chk(nm, d, act == want, act, want);
    endtask

    initial begin
        int   c;
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            m_data[d] = 0;
            m_led[d]  = 0;
        end
        rst_n = 1'b0;
        rxd   = '1;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst_n    = 1'b1;
        checking = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1 direct: clean character, then a forced-low stop bit.
        send_frame(0, 'hA5, 1'b0, 1'b0);
        drive(0, 1'b1, 2 * CLK_BIT);
        lit("lit_a5_data", 0, o_data[0], 'hA5);
        lit("lit_a5_led", 0, o_led[0], 'hA5);
        send_frame(0, 'h55, 1'b0, 1'b1);
        drive(0, 1'b1, 2 * CLK_BIT);
        lit("lit_55_data", 0, o_data[0], 'h55);
        lit("lit_55_led_held", 0, o_led[0], 'hA5);

        // 8E1: correct parity, then flipped parity.
        send_frame(1, 'h3C, 1'b0, 1'b0);
        drive(1, 1'b1, 2 * CLK_BIT);
        lit("lit_3c_led", 1, o_led[1], 'h3C);
        send_frame(1, 'hC3, 1'b1, 1'b0);
        drive(1, 1'b1, 2 * CLK_BIT);
        lit("lit_bad_par_data", 1, o_data[1], 'hC3);
        lit("lit_bad_par_led_held", 1, o_led[1], 'h3C);

        // 16-bit shifting bank, back-to-back characters.
        send_frame(2, 'h12, 1'b0, 1'b0);
        send_frame(2, 'h34, 1'b0, 1'b0);
        drive(2, 1'b1, 2 * CLK_BIT);
        lit("lit_shift_1234", 2, o_led[2], 'h1234);

        // 7O1 shifting into an 8-bit bank: only the newest char plus one older bit survive.
        send_frame(3, 'h55, 1'b0, 1'b0);
        send_frame(3, 'h2A, 1'b0, 1'b0);
        drive(3, 1'b1, 2 * CLK_BIT);
        lit("lit_7bit_shift", 3, o_led[3], 'hAA);

        // Short low glitch must be ignored, then a normal character.
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 300);
        send_frame(0, 'hFF, 1'b0, 1'b0);
        drive(0, 1'b1, 2 * CLK_BIT);
        lit("lit_ff_led", 0, o_led[0], 'hFF);

        // Line break: three character times of low, one frame error per ~9.5 bit times.
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            e.due  = c + 9 * CLK_BIT + CLK_BIT / 2 + k * (19 * CLK_BIT / 2);
            e.data = 0;
            e.ok   = 1'b0;
            e.fe   = 1'b1;
            e.pe   = 1'b0;
            q[0].push_back(e);
        end
        drive(0, 1'b0, 3 * (19 * CLK_BIT / 2) + 44);
        drive(0, 1'b1, 3 * CLK_BIT);
        lit("lit_break_data", 0, o_data[0], 0);
        lit("lit_break_led", 0, o_led[0], 'hFF);

        // Reset in the middle of 0x81 (during data bit 4), then 0x0F.
        drive(0, 1'b0, CLK_BIT);
        drive(0, 1'b1, CLK_BIT);
        drive(0, 1'b0, 3 * CLK_BIT + CLK_BIT / 2);
        rst_n = 1'b0;
        rxd   = '1;
        for (int d = 0; d < ND; d++) begin
            q[d].delete();
            m_data[d] = 0;
            m_led[d]  = 0;
        end
        repeat (10) @(negedge clk);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        send_frame(0, 'h0F, 1'b0, 1'b0);
        drive(0, 1'b1, 2 * CLK_BIT);
        lit("lit_0f_data", 0, o_data[0], 'h0F);
        lit("lit_0f_led", 0, o_led[0], 'h0F);

        fork
            rand_seq(0, 6);
            rand_seq(1, 6);
            rand_seq(2, 6);
            rand_seq(3, 6);
        join

        repeat (50) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("queue_drained", d, q[d].size() == 0, q[d].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
